// File: rtl/control_unit_fsm_if.sv
// ----------------------------------------------------------------------------
// control_unit_fsm_if
//   Control bundle between the instruction sequencer and the 8-bit computer
//   datapath / memory system.
//
//   Datapath -> controller : IR (opcode), CCR ({N,Z,V,C})
//   Controller -> datapath : IR_Load, MAR_Load, PC_Load, PC_Inc, A_Load,
//                            B_Load, ALU_Sel[2:0], CCR_Load, Bus1_Sel[1:0],
//                            Bus2_Sel[1:0], write, illegal_op
//
//   master : the controller (drives strobes, reads IR/CCR)
//   slave  : the datapath   (reads strobes, drives IR/CCR)
// ----------------------------------------------------------------------------
interface control_unit_fsm_if;
    logic [7:0] IR;
    logic [3:0] CCR;
    logic       IR_Load;
    logic       MAR_Load;
    logic       PC_Load;
    logic       PC_Inc;
    logic       A_Load;
    logic       B_Load;
    logic [2:0] ALU_Sel;
    logic       CCR_Load;
    logic [1:0] Bus1_Sel;
    logic [1:0] Bus2_Sel;
    logic       write;
    logic       illegal_op;

    modport master (
        input  IR, CCR,
        output IR_Load, MAR_Load, PC_Load, PC_Inc, A_Load, B_Load,
               ALU_Sel, CCR_Load, Bus1_Sel, Bus2_Sel, write, illegal_op
    );

    modport slave (
        output IR, CCR,
        input  IR_Load, MAR_Load, PC_Load, PC_Inc, A_Load, B_Load,
               ALU_Sel, CCR_Load, Bus1_Sel, Bus2_Sel, write, illegal_op
    );
endinterface

// File: rtl/control_unit_fsm.sv
// ----------------------------------------------------------------------------
// control_unit_fsm
//   Moore instruction sequencer for the 8-bit computer. Fetches opcodes and
//   operands from the synchronous program ROM through MAR/PC, decodes them and
//   drives every datapath strobe.
//
//   Parameters
//     ADDR_BYTES : operand address bytes for *_DIR and branches (1 or 2).
//                  With 2, the leading high byte is fetched and discarded.
//   Ports
//     clk   : system clock, rising edge
//     reset : asynchronous, active-low
//     bus   : control_unit_fsm_if.master (IR/CCR in, all strobes out)
// ----------------------------------------------------------------------------
module control_unit_fsm #(
    parameter int unsigned ADDR_BYTES = 2
) (
    input  logic               clk,
    input  logic               reset,
    control_unit_fsm_if.master bus
);

    localparam logic [7:0] OP_LDA_IMM = 8'h86;
    localparam logic [7:0] OP_LDA_DIR = 8'h87;
    localparam logic [7:0] OP_LDB_IMM = 8'h88;
    localparam logic [7:0] OP_LDB_DIR = 8'h89;
    localparam logic [7:0] OP_STA_DIR = 8'h96;
    localparam logic [7:0] OP_STB_DIR = 8'h97;

    localparam logic [1:0] B1_PC  = 2'b00;
    localparam logic [1:0] B1_A   = 2'b01;
    localparam logic [1:0] B1_B   = 2'b10;
    localparam logic [1:0] B2_ALU = 2'b00;
    localparam logic [1:0] B2_B1  = 2'b01;
    localparam logic [1:0] B2_MEM = 2'b10;

    // S_RESET is only occupied while reset is asserted, so that the first
    // edge after release presents FETCH_0 with every strobe low beforehand.
    typedef enum logic [4:0] {
        S_RESET,
        FETCH_0, FETCH_1, FETCH_2, DECODE_3,
        IMM_4, IMM_5, IMM_6,
        ADR_4, ADR_5, ADR_6, ADR_7, ADR_8,
        LD_9, LD_10,
        ST_9,
        BR_8,
        ALU_4
    } state_t;

    typedef struct packed {
        logic       ir_load;
        logic       mar_load;
        logic       pc_inc;
        logic       a_load;
        logic       b_load;
        logic [2:0] alu_sel;
        logic       ccr_load;
        logic [1:0] bus1_sel;
        logic [1:0] bus2_sel;
        logic       write;
    } ctl_t;

    state_t state;
    state_t state_nxt;
    ctl_t   ctl_q;

    function automatic logic is_imm(input logic [7:0] op);
        return (op == OP_LDA_IMM) || (op == OP_LDB_IMM);
    endfunction

    function automatic logic is_ld_dir(input logic [7:0] op);
        return (op == OP_LDA_DIR) || (op == OP_LDB_DIR);
    endfunction

    function automatic logic is_st_dir(input logic [7:0] op);
        return (op == OP_STA_DIR) || (op == OP_STB_DIR);
    endfunction

    function automatic logic is_branch(input logic [7:0] op);
        return (op >= 8'h20) && (op <= 8'h28);
    endfunction

    function automatic logic is_alu(input logic [7:0] op);
        return (op >= 8'h42) && (op <= 8'h4C);
    endfunction

    function automatic logic is_legal(input logic [7:0] op);
        return is_imm(op) || is_ld_dir(op) || is_st_dir(op) ||
               is_branch(op) || is_alu(op);
    endfunction

    // {use_b, alu_sel}: use_b routes B onto Bus1 and makes B the destination.
    function automatic logic [3:0] alu_decode(input logic [7:0] op);
        logic [3:0] r;
        r = '0;
        case (op)
            8'h42:   r = {1'b0, 3'b000};
            8'h43:   r = {1'b0, 3'b001};
            8'h44:   r = {1'b0, 3'b010};
            8'h45:   r = {1'b0, 3'b011};
            8'h46:   r = {1'b0, 3'b100};
            8'h47:   r = {1'b1, 3'b100};
            8'h48:   r = {1'b0, 3'b101};
            8'h49:   r = {1'b1, 3'b101};
            8'h4A:   r = {1'b0, 3'b110};
            8'h4B:   r = {1'b0, 3'b111};
            8'h4C:   r = {1'b1, 3'b111};
            default: r = '0;
        endcase
        return r;
    endfunction

    // CCR = {N,Z,V,C}
    function automatic logic branch_taken(input logic [7:0] op, input logic [3:0] f);
        logic t;
        t = 1'b0;
        case (op)
            8'h20:   t = 1'b1;
            8'h21:   t = f[3];
            8'h22:   t = ~f[3];
            8'h23:   t = f[2];
            8'h24:   t = ~f[2];
            8'h25:   t = f[1];
            8'h26:   t = ~f[1];
            8'h27:   t = f[0];
            8'h28:   t = ~f[0];
            default: t = 1'b0;
        endcase
        return t;
    endfunction

    function automatic state_t after_addr(input logic [7:0] op);
        return is_branch(op) ? BR_8 : ADR_8;
    endfunction

    function automatic state_t next_state(input state_t s, input logic [7:0] op);
        state_t n;
        n = FETCH_0;
        case (s)
            S_RESET:  n = FETCH_0;
            FETCH_0:  n = FETCH_1;
            FETCH_1:  n = FETCH_2;
            FETCH_2:  n = DECODE_3;
            DECODE_3: begin
                if (is_imm(op))
                    n = IMM_4;
                else if (is_ld_dir(op) || is_st_dir(op) || is_branch(op))
                    n = ADR_4;
                else if (is_alu(op))
                    n = ALU_4;
                else
                    n = FETCH_0;
            end
            IMM_4:    n = IMM_5;
            IMM_5:    n = IMM_6;
            ADR_4:    n = ADR_5;
            ADR_5:    n = (ADDR_BYTES >= 2) ? ADR_6 : after_addr(op);
            ADR_6:    n = ADR_7;
            ADR_7:    n = after_addr(op);
            ADR_8:    n = is_st_dir(op) ? ST_9 : LD_9;
            LD_9:     n = LD_10;
            default:  n = FETCH_0;
        endcase
        return n;
    endfunction

    function automatic ctl_t decode(input state_t s, input logic [7:0] op);
        ctl_t       c;
        logic [3:0] a;
        c = '0;
        a = alu_decode(op);
        case (s)
            FETCH_0, IMM_4, ADR_4, ADR_6: begin
                c.bus1_sel = B1_PC;
                c.bus2_sel = B2_B1;
                c.mar_load = 1'b1;
            end
            FETCH_1, IMM_5, ADR_5, ADR_7: c.pc_inc = 1'b1;
            FETCH_2: begin
                c.bus2_sel = B2_MEM;
                c.ir_load  = 1'b1;
            end
            IMM_6, LD_10: begin
                c.bus2_sel = B2_MEM;
                c.a_load   = (op == OP_LDA_IMM) || (op == OP_LDA_DIR);
                c.b_load   = (op == OP_LDB_IMM) || (op == OP_LDB_DIR);
            end
            ADR_8: begin
                c.bus2_sel = B2_MEM;
                c.mar_load = 1'b1;
            end
            ST_9: begin
                c.bus1_sel = (op == OP_STA_DIR) ? B1_A : B1_B;
                c.write    = 1'b1;
            end
            BR_8: c.bus2_sel = B2_MEM;
            ALU_4: begin
                c.bus1_sel = a[3] ? B1_B : B1_A;
                c.bus2_sel = B2_ALU;
                c.alu_sel  = a[2:0];
                c.a_load   = ~a[3];
                c.b_load   = a[3];
                c.ccr_load = 1'b1;
            end
            default: c = '0;
        endcase
        return c;
    endfunction

    always_comb begin
        state_nxt = next_state(state, bus.IR);
    end

    // Strobes are registered from the decode of the state being entered, so
    // they line up with the state register and clear asynchronously on reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= S_RESET;
            ctl_q <= '0;
        end else begin
            state <= state_nxt;
            ctl_q <= decode(state_nxt, bus.IR);
        end
    end

    assign bus.IR_Load  = ctl_q.ir_load;
    assign bus.MAR_Load = ctl_q.mar_load;
    assign bus.PC_Inc   = ctl_q.pc_inc;
    assign bus.A_Load   = ctl_q.a_load;
    assign bus.B_Load   = ctl_q.b_load;
    assign bus.ALU_Sel  = ctl_q.alu_sel;
    assign bus.CCR_Load = ctl_q.ccr_load;
    assign bus.Bus1_Sel = ctl_q.bus1_sel;
    assign bus.Bus2_Sel = ctl_q.bus2_sel;
    assign bus.write    = ctl_q.write;

    // These two depend on IR/CCR as seen during the state itself: IR is only
    // valid once DECODE_3 is reached, and the branch condition uses CCR in BR_8.
    assign bus.PC_Load    = (state == BR_8) && branch_taken(bus.IR, bus.CCR);
    assign bus.illegal_op = (state == DECODE_3) && !is_legal(bus.IR);

endmodule

// File: tb/tb_control_unit_fsm.sv
// ----------------------------------------------------------------------------
// tb_control_unit_fsm
//   Self-checking bench for control_unit_fsm. One instance with ADDR_BYTES=2
//   and one with ADDR_BYTES=1; IR/CCR are driven directly on each interface.
// ----------------------------------------------------------------------------
module tb_control_unit_fsm;

    logic clk = 1'b0;
    logic reset;
    logic reset1;

    always #5 clk = ~clk;

    control_unit_fsm_if cu ();
    control_unit_fsm_if cu1 ();

    control_unit_fsm #(.ADDR_BYTES(2)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (cu.master)
    );

    control_unit_fsm #(.ADDR_BYTES(1)) dut1 (
        .clk   (clk),
        .reset (reset1),
        .bus   (cu1.master)
    );

    typedef struct {
        logic [7:0]  ir;
        logic [3:0]  ccr;
        int          len;
        logic [15:0] last;
        int          abs_cyc;
        string       name;
    } vec_t;

    vec_t tbl[31];
    int   checks   = 0;
    int   failures = 0;
    int   cyc[2];

    // Packing: {IR_Load,MAR_Load,PC_Load,PC_Inc,A_Load,B_Load,ALU_Sel,
    //           CCR_Load,Bus1_Sel,Bus2_Sel,write,illegal_op}
    function automatic logic [15:0] mk(input logic irl, input logic marl,
                                       input logic pcl, input logic pci,
                                       input logic al, input logic bl,
                                       input logic [2:0] alu, input logic ccrl,
                                       input logic [1:0] b1, input logic [1:0] b2,
                                       input logic wr, input logic ill);
        return {irl, marl, pcl, pci, al, bl, alu, ccrl, b1, b2, wr, ill};
    endfunction

    function automatic logic [15:0] vec_of(input int sel);
        if (sel == 0)
            return {cu.IR_Load, cu.MAR_Load, cu.PC_Load, cu.PC_Inc, cu.A_Load,
                    cu.B_Load, cu.ALU_Sel, cu.CCR_Load, cu.Bus1_Sel,
                    cu.Bus2_Sel, cu.write, cu.illegal_op};
        return {cu1.IR_Load, cu1.MAR_Load, cu1.PC_Load, cu1.PC_Inc, cu1.A_Load,
                cu1.B_Load, cu1.ALU_Sel, cu1.CCR_Load, cu1.Bus1_Sel,
                cu1.Bus2_Sel, cu1.write, cu1.illegal_op};
    endfunction

    task automatic check(input string name, input logic [15:0] act,
                         input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    task automatic put(input int idx, input logic [7:0] ir, input logic [3:0] ccr,
                       input int len, input logic [15:0] last, input int abs_cyc,
                       input string name);
        tbl[idx].ir      = ir;
        tbl[idx].ccr     = ccr;
        tbl[idx].len     = len;
        tbl[idx].last    = last;
        tbl[idx].abs_cyc = abs_cyc;
        tbl[idx].name    = name;
    endtask

    task automatic next_cycle(input int sel);
        @(negedge clk);
        cyc[sel] = cyc[sel] + 1;
    endtask

    // Entered on the negedge of an instruction's FETCH_0 cycle; leaves on the
    // negedge of the following instruction's FETCH_0 cycle.
    task automatic run_instr(input int sel, input int idx, input bit chk_abs);
        logic [15:0] v;
        bit          stray;
        stray = 1'b0;
        if (sel == 0) begin
            cu.IR  = tbl[idx].ir;
            cu.CCR = tbl[idx].ccr;
        end else begin
            cu1.IR  = tbl[idx].ir;
            cu1.CCR = tbl[idx].ccr;
        end
        for (int c = 1; c <= tbl[idx].len; c++) begin
            v = vec_of(sel);
            if (c == 1)
                check({tbl[idx].name, " fetch0"}, v, F0);
            if (c == 3)
                check({tbl[idx].name, " fetch2"}, v, F2);
            if (c < tbl[idx].len && (v[1] || v[0]))
                stray = 1'b1;
            if (c == tbl[idx].len) begin
                check({tbl[idx].name, " last"}, v, tbl[idx].last);
                if (chk_abs && tbl[idx].abs_cyc != 0)
                    check_int({tbl[idx].name, " cycle"}, cyc[sel], tbl[idx].abs_cyc);
            end
            next_cycle(sel);
        end
        check_int({tbl[idx].name, " stray write/illegal"}, int'(stray), 0);
    endtask

    logic [15:0] F0, F2;

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        F0 = mk(0,1,0,0,0,0,3'd0,0,2'd0,2'd1,0,0);
        F2 = mk(1,0,0,0,0,0,3'd0,0,2'd0,2'd2,0,0);

        put(0,  8'h88, 4'h0, 7,  mk(0,0,0,0,0,1,3'd0,0,2'd0,2'd2,0,0), 7,  "LDB_IMM");
        put(1,  8'h86, 4'h0, 7,  mk(0,0,0,0,1,0,3'd0,0,2'd0,2'd2,0,0), 14, "LDA_IMM");
        put(2,  8'h42, 4'h0, 5,  mk(0,0,0,0,1,0,3'd0,1,2'd1,2'd0,0,0), 19, "ADD_AB");
        put(3,  8'h96, 4'h0, 10, mk(0,0,0,0,0,0,3'd0,0,2'd1,2'd0,1,0), 29, "STA_DIR");
        put(4,  8'h20, 4'h0, 9,  mk(0,0,1,0,0,0,3'd0,0,2'd0,2'd2,0,0), 38, "BRA_1");
        put(5,  8'h20, 4'h0, 9,  mk(0,0,1,0,0,0,3'd0,0,2'd0,2'd2,0,0), 47, "BRA_2");
        put(6,  8'h23, 4'h0, 9,  mk(0,0,0,0,0,0,3'd0,0,2'd0,2'd2,0,0), 0,  "BEQ_nt");
        put(7,  8'h23, 4'h4, 9,  mk(0,0,1,0,0,0,3'd0,0,2'd0,2'd2,0,0), 0,  "BEQ_t");
        put(8,  8'h24, 4'h4, 9,  mk(0,0,0,0,0,0,3'd0,0,2'd0,2'd2,0,0), 0,  "BNE_nt");
        put(9,  8'h21, 4'h8, 9,  mk(0,0,1,0,0,0,3'd0,0,2'd0,2'd2,0,0), 0,  "BMI_t");
        put(10, 8'h22, 4'h8, 9,  mk(0,0,0,0,0,0,3'd0,0,2'd0,2'd2,0,0), 0,  "BPL_nt");
        put(11, 8'h25, 4'h2, 9,  mk(0,0,1,0,0,0,3'd0,0,2'd0,2'd2,0,0), 0,  "BVS_t");
        put(12, 8'h26, 4'h2, 9,  mk(0,0,0,0,0,0,3'd0,0,2'd0,2'd2,0,0), 0,  "BVC_nt");
        put(13, 8'h27, 4'h1, 9,  mk(0,0,1,0,0,0,3'd0,0,2'd0,2'd2,0,0), 0,  "BCS_t");
        put(14, 8'h28, 4'h1, 9,  mk(0,0,0,0,0,0,3'd0,0,2'd0,2'd2,0,0), 0,  "BCC_nt");
        put(15, 8'h87, 4'h0, 11, mk(0,0,0,0,1,0,3'd0,0,2'd0,2'd2,0,0), 0,  "LDA_DIR");
        put(16, 8'h89, 4'h0, 11, mk(0,0,0,0,0,1,3'd0,0,2'd0,2'd2,0,0), 0,  "LDB_DIR");
        put(17, 8'h97, 4'h0, 10, mk(0,0,0,0,0,0,3'd0,0,2'd2,2'd0,1,0), 0,  "STB_DIR");
        put(18, 8'h47, 4'h0, 5,  mk(0,0,0,0,0,1,3'd4,1,2'd2,2'd0,0,0), 0,  "INCB");
        put(19, 8'h43, 4'h0, 5,  mk(0,0,0,0,1,0,3'd1,1,2'd1,2'd0,0,0), 0,  "SUB_AB");
        put(20, 8'h4A, 4'h0, 5,  mk(0,0,0,0,1,0,3'd6,1,2'd1,2'd0,0,0), 0,  "XOR_AB");
        put(21, 8'h4C, 4'h0, 5,  mk(0,0,0,0,0,1,3'd7,1,2'd2,2'd0,0,0), 0,  "NOTB");
        put(22, 8'h48, 4'h0, 5,  mk(0,0,0,0,1,0,3'd5,1,2'd1,2'd0,0,0), 0,  "DECA");
        put(23, 8'h00, 4'h0, 4,  mk(0,0,0,0,0,0,3'd0,0,2'd0,2'd0,0,1), 0,  "ILL_00");
        put(24, 8'hFF, 4'hF, 4,  mk(0,0,0,0,0,0,3'd0,0,2'd0,2'd0,0,1), 0,  "ILL_FF");
        put(25, 8'h4D, 4'h0, 4,  mk(0,0,0,0,0,0,3'd0,0,2'd0,2'd0,0,1), 0,  "ILL_4D");
        put(26, 8'h29, 4'h0, 4,  mk(0,0,0,0,0,0,3'd0,0,2'd0,2'd0,0,1), 0,  "ILL_29");
        put(27, 8'h87, 4'h0, 9,  mk(0,0,0,0,1,0,3'd0,0,2'd0,2'd2,0,0), 9,  "AB1_LDA_DIR");
        put(28, 8'h20, 4'h0, 7,  mk(0,0,1,0,0,0,3'd0,0,2'd0,2'd2,0,0), 16, "AB1_BRA");
        put(29, 8'h96, 4'h0, 8,  mk(0,0,0,0,0,0,3'd0,0,2'd1,2'd0,1,0), 24, "AB1_STA_DIR");
        put(30, 8'h23, 4'h0, 7,  mk(0,0,0,0,0,0,3'd0,0,2'd0,2'd2,0,0), 31, "AB1_BEQ_nt");

        // Reset held low for 3 cycles: everything quiet.
        reset   = 1'b0;
        reset1  = 1'b0;
        cu.IR   = 8'h00;
        cu.CCR  = 4'h0;
        cu1.IR  = 8'h00;
        cu1.CCR = 4'h0;
        cyc[0]  = 0;
        cyc[1]  = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("reset quiet", vec_of(0), 16'h0000);
        end
        check("reset1 quiet", vec_of(1), 16'h0000);

        // Release; the first edge afterwards presents FETCH_0 (cycle 1).
        reset = 1'b1;
        next_cycle(0);

        for (int i = 0; i <= 26; i++)
            run_instr(0, i, 1'b1);
        check("after table fetch0", vec_of(0), F0);

        // Reset asserted while ST_9 is driving write.
        cu.IR = 8'h96;
        for (int c = 1; c < 10; c++) next_cycle(0);
        check("ST_9 write", vec_of(0), tbl[3].last);
        reset = 1'b0;
        #1;
        check("reset in ST_9", vec_of(0), 16'h0000);
        @(negedge clk);
        check("reset in ST_9 held", vec_of(0), 16'h0000);
        reset = 1'b1;
        next_cycle(0);
        check("restart after ST_9", vec_of(0), F0);

        // Reset asserted during ADR_8, then a full clean STA.
        for (int c = 1; c < 9; c++) next_cycle(0);
        check("ADR_8", vec_of(0), mk(0,1,0,0,0,0,3'd0,0,2'd0,2'd2,0,0));
        reset = 1'b0;
        #1;
        check("reset in ADR_8", vec_of(0), 16'h0000);
        @(negedge clk);
        reset = 1'b1;
        next_cycle(0);
        run_instr(0, 3, 1'b0);
        check("after restart fetch0", vec_of(0), F0);

        // ADDR_BYTES=1 build.
        reset1 = 1'b1;
        next_cycle(1);
        for (int i = 27; i <= 30; i++)
            run_instr(1, i, 1'b1);
        check("AB1 end fetch0", vec_of(1), F0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
